bp_table_scheduler: RTL
=======================

Name: bp_table_scheduler

Overview:
- Shares one single-port predictor/loop-counter table (2^IDX_W entries) between the fetch-stage lookup and EX-stage resolution updates.
- Fetch lookups have priority. EX updates are buffered in a small FIFO and drained into idle table cycles.
- Also sequences a zero-fill sweep of the table after reset and on flush, and holds the predictor not-ready during the sweep.

Parameters:
- WIDTH, 32, PC width.
- IDX_W, 8, table index width; index is PC[IDX_W-1:0].
- DATA_W, 9, entry width (MSB loop_en, lower bits counter).
- FIFO_DEPTH, 4, update FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- PC_F  in  WIDTH  fetch PC.
- branch_en_F  in  1  lookup request this cycle.
- PC_EX  in  WIDTH  resolving-branch PC.
- branch_en_EX  in  1  update request this cycle.
- upd_wdata  in  DATA_W  new entry value from EX.
- flush_req  in  1  one-cycle pulse: drain pending updates, then re-clear table.
- lookup_valid  out  1  lookup_data valid.
- lookup_data  out  DATA_W  entry read for the previous cycle's granted lookup.
- fetch_stall  out  1  lookup not granted this cycle; fetch holds PC_F.
- ex_stall  out  1  FIFO cannot accept an update this cycle.
- ready  out  1  table initialised, lookups accepted.
- tbl_en  out  1  table access strobe.
- tbl_we  out  1  write (1) / read (0).
- tbl_addr  out  IDX_W  table index.
- tbl_wdata  out  DATA_W  write data.
- tbl_rdata  in  DATA_W  read data, valid one cycle after a read strobe.

Behaviour:
- One clock clk. Reset rst is synchronous and active-high.
- Reset:
  - FSM goes to INIT, sweep pointer = 0, FIFO empty.
  - lookup_valid=0, lookup_data=0, ready=0, fetch_stall=1, ex_stall=1, tbl_en=0, tbl_we=0, tbl_addr=0, tbl_wdata=0.
  - Reset mid-sweep or mid-drain aborts the operation, discards FIFO contents and restarts INIT at 0.
- FSM states: INIT, RUN, DRAIN.
- INIT:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=ptr, tbl_wdata=0, ptr+1.
  - After writing 2^IDX_W-1, go to RUN. Sweep takes exactly 2^IDX_W cycles.
  - ready=0, fetch_stall=1, ex_stall=1. Requests are ignored, not queued.
- RUN, per-cycle grant priority (one table access per cycle):
  1. FIFO full AND branch_en_F: pop the FIFO head (write) and assert fetch_stall=1. Full FIFO beats fetch to prevent EX deadlock.
  2. Else if branch_en_F: read at PC_F[IDX_W-1:0], fetch_stall=0.
  3. Else if FIFO not empty: pop head, tbl_we=1.
  4. Else: tbl_en=0.
- Lookup latency: lookup_valid is asserted exactly 1 cycle after a granted read, with lookup_data=tbl_rdata. lookup_data holds its last value when invalid.
- Lookups do not forward from pending FIFO entries. A read may return stale data while an update for the same index is queued; this is accepted predictor inaccuracy.
- FIFO:
  - Push on branch_en_EX && !ex_stall, storing {PC_EX[IDX_W-1:0], upd_wdata}.
  - ex_stall = (count==FIFO_DEPTH) && !pop_this_cycle. Push and pop in the same cycle when full is allowed; count is unchanged.
  - Drain order is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- DRAIN:
  - Entered from RUN on flush_req. flush_req is ignored in INIT or DRAIN.
  - fetch_stall=1, ex_stall=1, ready=0. Pop one entry per cycle.
  - When the FIFO is empty (same cycle if already empty), go to INIT.
  - An EX update arriving in the flush_req cycle is not accepted (ex_stall is forced high that cycle).
- ready=1 only in RUN.

Optional Feature:
- Macro: BP_SCHED_COALESCE_EN.
- Defined: a push whose index equals a queued entry that is not being popped this cycle overwrites that entry's data in place. count is unchanged and the entry keeps its FIFO position. The equal-index check is against all valid entries; the lowest slot number wins if multiple match. ex_stall is deasserted for such a push even when full.
- Undefined: every accepted push allocates a new entry.

Test Plan:
- Reset, IDX_W=8 -> 256 consecutive writes with addr 0..255, data 0; ready rises on cycle 257; no request granted before then.
- RUN, branch_en_F with PC_F=0x1C4 -> tbl_addr=0xC4 read; next cycle lookup_valid=1, lookup_data=tbl_rdata.
- Push 4 updates with branch_en_F held high -> on the 4th-entry-full cycle, fetch_stall=1 and the head entry is written; ex_stall=0 that cycle since a pop occurs.
- Fetch idle, 3 updates queued (idx 5,9,5) -> writes drain in order 5,9,5 over 3 cycles; FIFO empty after.
- flush_req with 2 queued -> 2 drain writes, then 256-entry sweep; ready=0 throughout; branch_en_EX during flush_req cycle is stalled and not written.
- With BP_SCHED_COALESCE_EN, updates idx 7 data 0x03 then idx 7 data 0x04 while fetch busy -> count=1, single write of 0x04 to index 7.

Source files
------------

// File: rtl/bp_table_scheduler.sv
// Arbitrates one single-port predictor table between fetch lookups and queued EX updates.
// Optional BP_SCHED_COALESCE_EN merges an update into a queued entry with the same index.
module bp_table_scheduler #(
    parameter int WIDTH      = 32,
    parameter int IDX_W      = 8,
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  PC_F,
    input  logic              branch_en_F,
    input  logic [WIDTH-1:0]  PC_EX,
    input  logic              branch_en_EX,
    input  logic [DATA_W-1:0] upd_wdata,
    input  logic              flush_req,
    output logic              lookup_valid,
    output logic [DATA_W-1:0] lookup_data,
    output logic              fetch_stall,
    output logic              ex_stall,
    output logic              ready,
    output logic              tbl_en,
    output logic              tbl_we,
    output logic [IDX_W-1:0]  tbl_addr,
    output logic [DATA_W-1:0] tbl_wdata,
    input  logic [DATA_W-1:0] tbl_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  q_idx  [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic              rd_q;
    logic [DATA_W-1:0] held;

    logic              full, empty, pop, push, alloc, grant_rd;
    logic              merge;
    logic [PW-1:0]     merge_slot;
    logic [IDX_W-1:0]  upd_idx, fetch_idx;

    logic unused_pc;
    assign unused_pc = ^{PC_F[WIDTH-1:IDX_W], PC_EX[WIDTH-1:IDX_W]};

    assign upd_idx   = PC_EX[IDX_W-1:0];
    assign fetch_idx = PC_F[IDX_W-1:0];
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);

    // State register and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            ptr    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rd_q   <= 1'b0;
            held   <= '0;
        end else begin
            state <= state_next;
            ptr   <= (state == INIT) ? ptr + 1'b1 : '0;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (alloc)
                wr_ptr <= wr_ptr + 1'b1;
            count <= count + CW'(alloc) - CW'(pop);
            rd_q  <= grant_rd;
            if (rd_q)
                held <= tbl_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            q_idx[wr_ptr]  <= upd_idx;
            q_data[wr_ptr] <= upd_wdata;
        end else if (push && merge) begin
            q_data[merge_slot] <= upd_wdata;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            INIT:    if (ptr == {IDX_W{1'b1}}) state_next = RUN;
            RUN:     if (flush_req) state_next = DRAIN;
            DRAIN:   if (count <= CW'(1)) state_next = INIT;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        tbl_en      = 1'b0;
        tbl_we      = 1'b0;
        tbl_addr    = '0;
        tbl_wdata   = '0;
        pop         = 1'b0;
        grant_rd    = 1'b0;
        fetch_stall = 1'b1;
        ready       = 1'b0;
        if (!rst) begin
            unique case (state)
                INIT: begin
                    tbl_en   = 1'b1;
                    tbl_we   = 1'b1;
                    tbl_addr = ptr;
                end
                RUN: begin
                    ready       = 1'b1;
                    fetch_stall = 1'b0;
                    // A full FIFO takes the port so EX cannot be starved
                    if (full && branch_en_F) begin
                        pop         = 1'b1;
                        fetch_stall = 1'b1;
                    end else if (branch_en_F) begin
                        grant_rd = 1'b1;
                        tbl_en   = 1'b1;
                        tbl_addr = fetch_idx;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end
                end
                DRAIN:   pop = !empty;
                default: ;
            endcase
        end
        if (pop) begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = q_idx[rd_ptr];
            tbl_wdata = q_data[rd_ptr];
        end
    end

`ifdef BP_SCHED_COALESCE_EN
    logic [PW-1:0] offs;

    // Descending scan so the lowest matching slot is the one kept
    always_comb begin
        merge      = 1'b0;
        merge_slot = '0;
        offs       = '0;
        for (int i = FIFO_DEPTH - 1; i >= 0; i--) begin
            offs = PW'(i) - rd_ptr;
            if (({1'b0, offs} < count) && (q_idx[i] == upd_idx)
                && !(pop && (PW'(i) == rd_ptr))) begin
                merge      = 1'b1;
                merge_slot = PW'(i);
            end
        end
    end
`else
    assign merge      = 1'b0;
    assign merge_slot = '0;
`endif

    assign ex_stall = rst || (state != RUN) || flush_req
                      || (full && !pop && !merge);
    assign push     = branch_en_EX && !ex_stall;
    assign alloc    = push && !merge;

    assign lookup_valid = rd_q;
    assign lookup_data  = rd_q ? tbl_rdata : held;

endmodule
